// File: rtl/parking_occupancy.sv
// rtl/parking_occupancy.sv - lot occupancy counter with BCD mirror and sticky error flags
// Counts edge-detected carIn/carOut events, saturating at 0 and CAPACITY.
module parking_occupancy #(
  parameter int CAPACITY = 20,
  parameter int WIDTH    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             carIn,
  input  logic             carOut,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] free_spaces,
  output logic             full,
  output logic             empty,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             in_q, in_d;
  logic             out_q, out_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic ev_in, ev_out;
  logic at_full, at_empty;

  assign ev_in    = carIn & ~in_q;
  assign ev_out   = carOut & ~out_q;
  assign at_full  = (count_q == CAP);
  assign at_empty = (count_q == '0);

  always_comb begin
    in_d    = carIn;
    out_d   = carOut;
    count_d = count_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    // Clear first so that a same-edge error still leaves the flag set.
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;

    if (ev_in && !ev_out) begin
      if (!at_full) begin
        count_d = count_q + ONE;
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          tens_d = tens_q + 4'd1;
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end else if (ev_out && !ev_in) begin
      if (!at_empty) begin
        count_d = count_q - ONE;
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          tens_d = tens_q - 4'd1;
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q    <= 1'b0;
      out_q   <= 1'b0;
      count_q <= '0;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      in_q    <= in_d;
      out_q   <= out_d;
      count_q <= count_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count         = count_q;
  assign free_spaces   = CAP - count_q;
  assign full          = at_full;
  assign empty         = at_empty;
  assign bcd_tens      = tens_q;
  assign bcd_ones      = ones_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_parking_occupancy.sv
// tb/tb_parking_occupancy.sv - bench for parking_occupancy (CAPACITY 20 and 3 instances)
module tb_parking_occupancy;

  localparam int W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ci = 1'b0, co = 1'b0, clr = 1'b0;
  logic ci3 = 1'b0, co3 = 1'b0, clr3 = 1'b0;
  logic [W-1:0] cnt, fs, cnt3, fs3;
  logic full, empty, ovf, unf, full3, empty3, ovf3, unf3;
  logic [3:0] tens, ones, tens3, ones3;

  always #5 clk = ~clk;

  parking_occupancy #(.CAPACITY(20), .WIDTH(W)) dut (
    .clk(clk), .reset(rst_n), .carIn(ci), .carOut(co), .clr_err(clr),
    .count(cnt), .free_spaces(fs), .full(full), .empty(empty),
    .bcd_tens(tens), .bcd_ones(ones), .overflow_err(ovf), .underflow_err(unf)
  );

  parking_occupancy #(.CAPACITY(3), .WIDTH(W)) dut3 (
    .clk(clk), .reset(rst_n), .carIn(ci3), .carOut(co3), .clr_err(clr3),
    .count(cnt3), .free_spaces(fs3), .full(full3), .empty(empty3),
    .bcd_tens(tens3), .bcd_ones(ones3), .overflow_err(ovf3), .underflow_err(unf3)
  );

  typedef struct {
    int   count;
    logic inq;
    logic outq;
    logic ovf;
    logic unf;
  } model_t;

  typedef struct {
    logic [2:0] stim;
    int         count;
  } vec_t;

  model_t m20, m3, mz;
  model_t sb20[$];
  model_t sb3[$];
  vec_t   vecs[$];
  int     checks = 0;
  int     failures = 0;

  function automatic model_t step(input model_t m, input int cap,
                                  input logic i, input logic o, input logic c);
    model_t n;
    logic ei, eo;
    n  = m;
    ei = i & ~m.inq;
    eo = o & ~m.outq;
    n.inq  = i;
    n.outq = o;
    if (c) begin
      n.ovf = 1'b0;
      n.unf = 1'b0;
    end
    if (ei && !eo) begin
      if (m.count < cap) n.count = m.count + 1;
      else n.ovf = 1'b1;
    end else if (eo && !ei) begin
      if (m.count > 0) n.count = m.count - 1;
      else n.unf = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input model_t m, input int cap,
                           input logic [W-1:0] c, input logic [W-1:0] f,
                           input logic fu, input logic em,
                           input logic [3:0] t, input logic [3:0] o,
                           input logic ov, input logic un);
    chk({tag, ".count"}, 32'(c), m.count);
    chk({tag, ".free_spaces"}, 32'(f), cap - m.count);
    chk({tag, ".full"}, 32'(fu), 32'(m.count == cap));
    chk({tag, ".empty"}, 32'(em), 32'(m.count == 0));
    chk({tag, ".bcd_tens"}, 32'(t), m.count / 10);
    chk({tag, ".bcd_ones"}, 32'(o), m.count % 10);
    chk({tag, ".overflow_err"}, 32'(ov), 32'(m.ovf));
    chk({tag, ".underflow_err"}, 32'(un), 32'(m.unf));
  endtask

  // Drive both instances for one cycle, queue the model result, compare after the edge.
  task automatic cycle(input logic [2:0] s20, input logic [2:0] s3);
    model_t e20, e3;
    @(negedge clk);
    {ci, co, clr}    = s20;
    {ci3, co3, clr3} = s3;
    m20 = step(m20, 20, s20[2], s20[1], s20[0]);
    sb20.push_back(m20);
    m3 = step(m3, 3, s3[2], s3[1], s3[0]);
    sb3.push_back(m3);
    @(posedge clk);
    #1;
    e20 = sb20.pop_front();
    e3  = sb3.pop_front();
    check_dut("c20", e20, 20, cnt, fs, full, empty, tens, ones, ovf, unf);
    check_dut("c3", e3, 3, cnt3, fs3, full3, empty3, tens3, ones3, ovf3, unf3);
  endtask

  task automatic check_reset_state(input string tag);
    check_dut({tag, ".c20"}, mz, 20, cnt, fs, full, empty, tens, ones, ovf, unf);
    check_dut({tag, ".c3"}, mz, 3, cnt3, fs3, full3, empty3, tens3, ones3, ovf3, unf3);
  endtask

  function automatic void add(input logic [2:0] s, input int c);
    vec_t v;
    v.stim  = s;
    v.count = c;
    vecs.push_back(v);
  endfunction

  initial begin
    logic a, b, c, d, e, f;
    int   hi;

    mz  = '{count: 0, inq: 1'b0, outq: 1'b0, ovf: 1'b0, unf: 1'b0};
    m20 = mz;
    m3  = mz;

    // Table: held entry counts once, climb to 10, step down to 5, simultaneous edges.
    for (int k = 0; k < 5; k++) add(3'b100, 1);
    add(3'b000, 1);
    for (int k = 2; k <= 10; k++) begin
      add(3'b100, k);
      add(3'b000, k);
    end
    add(3'b010, 9);
    add(3'b000, 9);
    for (int k = 8; k >= 5; k--) begin
      add(3'b010, k);
      add(3'b000, k);
    end
    add(3'b110, 5);
    add(3'b110, 5);
    add(3'b000, 5);
    add(3'b100, 6);
    add(3'b110, 5);
    add(3'b000, 5);

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].stim, 3'b000);
      chk($sformatf("vec%0d.count", i), 32'(cnt), vecs[i].count);
      chk($sformatf("vec%0d.bcd", i), {24'd0, tens, ones},
          32'(((vecs[i].count / 10) << 4) | (vecs[i].count % 10)));
      chk($sformatf("vec%0d.errs", i), {30'd0, ovf, unf}, 32'd0);
    end

    // CAPACITY=3: fill, simultaneous at full, overflow, clear.
    for (int k = 1; k <= 3; k++) begin
      cycle(3'b000, 3'b100);
      cycle(3'b000, 3'b000);
    end
    chk("cap3.filled_count", 32'(cnt3), 32'd3);
    chk("cap3.filled_full", 32'(full3), 32'd1);
    cycle(3'b000, 3'b110);
    chk("cap3.sim_full_count", 32'(cnt3), 32'd3);
    chk("cap3.sim_full_ovf", 32'(ovf3), 32'd0);
    cycle(3'b000, 3'b000);
    cycle(3'b000, 3'b100);
    chk("cap3.ovf_set", 32'(ovf3), 32'd1);
    chk("cap3.ovf_count", 32'(cnt3), 32'd3);
    cycle(3'b000, 3'b001);
    chk("cap3.ovf_cleared", 32'(ovf3), 32'd0);
    chk("cap3.clr_count", 32'(cnt3), 32'd3);

    // Drain, simultaneous at empty, underflow, same-edge clear loses to set.
    for (int k = 0; k < 3; k++) begin
      cycle(3'b000, 3'b010);
      cycle(3'b000, 3'b000);
    end
    chk("cap3.drained", 32'(cnt3), 32'd0);
    cycle(3'b000, 3'b110);
    chk("cap3.sim_empty_unf", 32'(unf3), 32'd0);
    cycle(3'b000, 3'b000);
    cycle(3'b000, 3'b010);
    chk("cap3.unf_set", 32'(unf3), 32'd1);
    cycle(3'b000, 3'b000);
    cycle(3'b000, 3'b011);
    chk("cap3.unf_set_wins", 32'(unf3), 32'd1);
    cycle(3'b000, 3'b011);
    chk("cap3.unf_cleared", 32'(unf3), 32'd0);
    chk("cap3.unf_count", 32'(cnt3), 32'd0);

    // Random stream with biased phases so both saturation limits get exercised.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #1;
        check_reset_state("held_reset");
        m20 = mz;
        m3  = mz;
        @(negedge clk);
        rst_n = 1'b1;
      end
      hi = ((i / 700) % 2 == 0) ? 6 : 2;
      a = ($urandom_range(0, 9) < hi);
      b = ($urandom_range(0, 9) < 8 - hi);
      c = ($urandom_range(0, 49) == 0);
      d = ($urandom_range(0, 9) < hi);
      e = ($urandom_range(0, 9) < 8 - hi);
      f = ($urandom_range(0, 49) == 0);
      cycle({a, b, c}, {d, e, f});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parking_occupancy.md
Name: parking_occupancy

Overview:
- Sits directly downstream of the car-direction detector FSM and consumes its carIn / carOut pulses.
- Keeps the number of cars currently inside the lot and computes free spaces and full/empty status.
- Maintains a parallel two-digit BCD copy of the occupancy for the 7-segment display driver.
- Latches sticky error flags when an entry arrives at full or an exit arrives at empty.

Parameters:
- CAPACITY, 20, lot capacity in cars. Legal range is 1..99.
- WIDTH, 7, bit width of count and free_spaces. Must satisfy 2^WIDTH > CAPACITY.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets the block).
- carIn  in  1  entry event from the upstream direction FSM, synchronous to clk.
- carOut  in  1  exit event from the upstream direction FSM, synchronous to clk.
- clr_err  in  1  synchronous clear of the sticky error flags.
- count  out  WIDTH  cars currently inside.
- free_spaces  out  WIDTH  CAPACITY - count.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- bcd_tens  out  4  tens digit of count, BCD.
- bcd_ones  out  4  ones digit of count, BCD.
- overflow_err  out  1  sticky: an entry was rejected at full.
- underflow_err  out  1  sticky: an exit was rejected at empty.

Behaviour:
- Reset (reset==0, asynchronous):
  - count=0, bcd_tens=0, bcd_ones=0, overflow_err=0, underflow_err=0.
  - Edge-detect registers cleared to 0.
  - free_spaces=CAPACITY, full=0, empty=1.
  - Reset asserted mid-operation clears immediately, independent of clk. Events coincident with reset are lost.
- Edge detection:
  - Registers in_q / out_q hold the previous carIn / carOut.
  - ev_in = carIn & ~in_q; ev_out = carOut & ~out_q.
  - A level held for N cycles counts once. A new event needs the input to return to 0 for at least 1 cycle.
- Latency:
  - An event sampled high at rising edge k is reflected on count, the BCD digits and the flags immediately after edge k (one registered stage).
  - free_spaces, full and empty decode combinationally from the registered count; they are glitch-free relative to count.
- Update rules, evaluated each rising edge (priority order):
  1. ev_in & ev_out: count unchanged, BCD unchanged, no error set.
  2. ev_in only: if count < CAPACITY, count+1 and BCD increment. Else count held and overflow_err <= 1.
  3. ev_out only: if count > 0, count-1 and BCD decrement. Else count held and underflow_err <= 1.
  4. No event: hold.
- BCD counter:
  - Increment: ones==9 → ones=0, tens+1; else ones+1.
  - Decrement: ones==0 → ones=9, tens-1; else ones-1.
  - Invariant checked by the bench: tens*10 + ones == count at all times. Digits never exceed 9.
- Sticky errors:
  - Once set, the flag holds until clr_err==1 at a rising edge.
  - If clr_err and a new error condition occur on the same edge, set wins (flag stays 1).
  - clr_err never affects count.
- Boundary conditions:
  - Count saturates at 0 and CAPACITY. No wrap-around ever.
  - Simultaneous in+out at full or at empty: no change, no error.

Test Plan:
- Reset release, then hold carIn=1 for 5 cycles → count=1, bcd=0/1, free_spaces=19, empty=0. A single increment only.
- 10 single-cycle carIn pulses separated by idle cycles → count=10, bcd_tens=1, bcd_ones=0. Then one carOut pulse → count=9, bcd=0/9.
- CAPACITY=3 override: 4 carIn pulses → count=3, full=1, overflow_err=1 after the 4th. Pulse clr_err → overflow_err=0, count still 3.
- From empty, one carOut pulse → count=0, underflow_err=1. Same-edge clr_err plus a further carOut edge → underflow_err stays 1.
- count=5: carIn and carOut rise on the same edge → count=5, no flags change. Also at count=CAPACITY: simultaneous events → no change, overflow_err stays 0.
- Random in/out pulse stream over 10k cycles, with reset pulled low asynchronously mid-stream → outputs return to reset values immediately. Scoreboard matches count, saturation and the tens*10+ones==count invariant.
